id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
Decode-to-execute pipeline register for the 32-bit MIPS pipeline. It captures the two register-file read operands, the decoded fields and the control bits each cycle. It performs WB-to-ID operand bypass and load-use hazard detection. On a hazard it inserts a one-cycle bubble and raises a stall to the PC and IF/ID stages.

Parameters:
N, 32, data/operand width
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset_in  input  1  synchronous, active-low reset (0 = reset)
flush_in  input  1  branch/jump squash; next EX contents become a bubble
id_valid_in  input  1  IF/ID holds a real instruction
rdata1_in  input  N  register-file read data, rs
rdata2_in  input  N  register-file read data, rt
rs_in, rt_in, rd_in  input  5 each  decoded register addresses
id_uses_rt_in  input  1  instruction reads rt as a source (R-type, store, beq)
imm_in  input  N  sign-extended immediate
pc4_in  input  N  PC+4 of decoded instruction
ctrl_in  input  10  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}
wb_reg_write_in  input  1  WB stage write enable
wb_write_reg_in  input  5  WB destination
wb_write_data_in  input  N  WB data
stall_out  output  1  combinational; hold PC and IF/ID this cycle
ex_valid_out  output  1  EX holds a real instruction
ex_a_out, ex_b_out  output  N  registered operands
ex_rs_out, ex_rt_out, ex_rd_out  output  5 each  registered addresses
ex_imm_out, ex_pc4_out  output  N  registered immediate / PC+4
ex_ctrl_out  output  10  registered control bits
bubble_count_out  output  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset (reset_in==0 at posedge): every registered output = 0 (valid, ctrl, data, addresses, counter). stall_out = 0 while reset_in==0.
- hazard (comb) = ex_valid_out & ex_ctrl_out.mem_read & (ex_rt_out!=0) & ((ex_rt_out==rs_in) | (id_uses_rt_in & ex_rt_out==rt_in)).
- stall_out = hazard & id_valid_in & ~flush_in & reset_in.
- Posedge update priority: reset > flush_in > stall_out > normal capture.
- Flush: load bubble; counter unchanged.
- Stall: load bubble; counter +1 (holds at 2^CNT_W-1).
- Bubble definition: ex_valid_out=0, ex_ctrl_out=0, all data/address fields=0.
- Normal capture: ex_valid_out = id_valid_in. ctrl captured only if id_valid_in, else ctrl = 0. All other fields captured as presented.
- Bypass, per operand, independent: if wb_reg_write_in & wb_write_reg_in!=0 & wb_write_reg_in==rs_in, ex_a_out captures wb_write_data_in, else rdata1_in. Same for rt / ex_b_out / rdata2_in.
- Register 0 never bypasses and never causes a hazard.
- Latency: 1 cycle ID->EX.
- Load-use costs exactly one bubble. After the bubble, ex_ctrl.mem_read=0, so the held instruction captures normally next cycle.
- Back-to-back loads with a dependency: each dependent pair stalls once; no double counting.
- Flush and hazard in the same cycle: flush wins, stall_out=0, counter unchanged.
- Reset mid-stall: reset wins; stall_out forced 0.

Decomposition:
- Shared package mips_pkg: CTRL_W=10; control bit index constants (CTRL_REG_WRITE..CTRL_ALU_OP); REG_ZERO=5'd0; BUBBLE_CTRL=0.
- Sub-module load_use_detect: combinational hazard equation only. Bypass muxes and registers stay in id_ex_reg.

Test Plan:
- Reset: reset_in=0 for 2 cycles with random inputs -> all outputs 0, stall_out=0. Release -> first valid instruction appears in EX after 1 cycle.
- Load-use: EX holds lw with rt=8; ID presents add rs=8 -> stall_out=1 for exactly one cycle; next EX is bubble (ctrl=0); following cycle add captured; bubble_count_out=1.
- Store dependency: EX lw rt=9; ID sw rt=9, id_uses_rt_in=1 -> stall. Repeat with id_uses_rt_in=0 -> no stall.
- $zero: EX lw rt=0; ID rs=0 -> no stall. wb writes reg 0 with 0xDEADBEEF -> no bypass.
- Bypass: wb writes reg 5 = 0x12345678; ID rs=5, rt=5, rdata1/2=0 -> ex_a_out=ex_b_out=0x12345678.
- Flush priority: hazard condition plus flush_in=1 -> stall_out=0, EX bubble, counter unchanged. Then force 65536 hazard bubbles -> counter saturates at 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared control-word layout and register constants for the MIPS pipeline.
package mips_pkg;
  localparam int CTRL_W = 10;
  localparam int CTRL_REG_WRITE = 9;
  localparam int CTRL_MEM_READ = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC = 5;
  localparam int CTRL_REG_DST = 4;
  localparam int CTRL_ALU_OP = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
  function automatic logic bypass_hit(input logic wr, input logic [4:0] wreg, input logic [4:0] src);
    return wr && wreg != REG_ZERO && wreg == src;
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
import mips_pkg::*;
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hazard
);
  assign hazard = ex_valid && ex_mem_read && ex_rt != REG_ZERO &&
                  (ex_rt == rs || (uses_rt && ex_rt == rt));
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID->EX pipeline register with WB bypass, load-use stall and bubble counter.
import mips_pkg::*;
module id_ex_reg #(
  parameter int N = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic              id_valid_in,
  input  logic [N-1:0]      rdata1_in,
  input  logic [N-1:0]      rdata2_in,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic              id_uses_rt_in,
  input  logic [N-1:0]      imm_in,
  input  logic [N-1:0]      pc4_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              wb_reg_write_in,
  input  logic [4:0]        wb_write_reg_in,
  input  logic [N-1:0]      wb_write_data_in,
  output logic              stall_out,
  output logic              ex_valid_out,
  output logic [N-1:0]      ex_a_out,
  output logic [N-1:0]      ex_b_out,
  output logic [4:0]        ex_rs_out,
  output logic [4:0]        ex_rt_out,
  output logic [4:0]        ex_rd_out,
  output logic [N-1:0]      ex_imm_out,
  output logic [N-1:0]      ex_pc4_out,
  output logic [CTRL_W-1:0] ex_ctrl_out,
  output logic [CNT_W-1:0]  bubble_count_out
);
  logic hazard;
  logic [N-1:0] a, b;
  load_use_detect u_detect (
    .ex_valid(ex_valid_out),
    .ex_mem_read(ex_ctrl_out[CTRL_MEM_READ]),
    .ex_rt(ex_rt_out),
    .rs(rs_in),
    .rt(rt_in),
    .uses_rt(id_uses_rt_in),
    .hazard(hazard)
  );
  assign stall_out = hazard && id_valid_in && !flush_in && reset_in;
  assign a = bypass_hit(wb_reg_write_in, wb_write_reg_in, rs_in) ? wb_write_data_in : rdata1_in;
  assign b = bypass_hit(wb_reg_write_in, wb_write_reg_in, rt_in) ? wb_write_data_in : rdata2_in;
  // reset, flush and stall all collapse to the same all-zero bubble
  always_ff @(posedge clk) begin
    if (!reset_in || flush_in || stall_out) begin
      ex_valid_out <= 1'b0;
      ex_a_out <= '0;
      ex_b_out <= '0;
      ex_rs_out <= REG_ZERO;
      ex_rt_out <= REG_ZERO;
      ex_rd_out <= REG_ZERO;
      ex_imm_out <= '0;
      ex_pc4_out <= '0;
      ex_ctrl_out <= BUBBLE_CTRL;
    end else begin
      ex_valid_out <= id_valid_in;
      ex_a_out <= a;
      ex_b_out <= b;
      ex_rs_out <= rs_in;
      ex_rt_out <= rt_in;
      ex_rd_out <= rd_in;
      ex_imm_out <= imm_in;
      ex_pc4_out <= pc4_in;
      ex_ctrl_out <= id_valid_in ? ctrl_in : BUBBLE_CTRL;
    end
    if (!reset_in) bubble_count_out <= '0;
    else if (stall_out && !(&bubble_count_out)) bubble_count_out <= bubble_count_out + 1'b1;
  end
endmodule
